// File: rtl/branch_resolve_unit.sv
// Branch unit: resolves EX branches/jumps, predicts fetch direction from a saturating-counter table.
// Latency: prediction is combinational (0 cycles); redirect/link/statistic outputs register 1 cycle after EX.
// Backpressure: none; upstream holds i_ex_valid low while EX is stalled, and each resolution is independent.
// Ports: i_clk/i_rst_n (async active-low); i_fetch_pc -> o_pred_taken (lookup);
//        i_ex_* (EX instruction, operands, offset, jump index, carried prediction);
//        o_redirect/o_redirect_pc (front-end flush), o_link_we/o_link_data (r31 write), o_mispredict_cnt.
module branch_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_BITS    = 2,
  parameter int STAT_BITS   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [XLEN-1:0]      i_fetch_pc,
  output logic                 o_pred_taken,
  input  logic                 i_ex_valid,
  input  logic [XLEN-1:0]      i_ex_pc,
  input  logic [2:0]           i_ex_brop,
  input  logic [XLEN-1:0]      i_ex_a,
  input  logic [XLEN-1:0]      i_ex_b,
  input  logic [15:0]          i_ex_offset,
  input  logic [25:0]          i_ex_target,
  input  logic                 i_ex_pred_taken,
  output logic                 o_redirect,
  output logic [XLEN-1:0]      o_redirect_pc,
  output logic                 o_link_we,
  output logic [XLEN-1:0]      o_link_data,
  output logic [STAT_BITS-1:0] o_mispredict_cnt
);

  localparam int IDX = $clog2(BHT_ENTRIES);
  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((2 ** (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_MIN  = '0;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JR   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_BLEZ = 3'b101;
  localparam logic [2:0] OP_BGTZ = 3'b110;
  localparam logic [2:0] OP_JAL  = 3'b111;

  logic [CNT_BITS-1:0] bht [BHT_ENTRIES];

  logic [IDX-1:0]      fetch_idx;
  logic [IDX-1:0]      ex_idx;
  logic [XLEN-1:0]     pc4;
  logic [XLEN-1:0]     off_ext;
  logic [XLEN-1:0]     btgt;
  logic [XLEN-1:0]     jtgt;
  logic                a_zero;
  logic                a_neg;
  logic                is_cond;
  logic                taken;
  logic                mispredict;
  logic [CNT_BITS-1:0] cnt_cur;
  logic [CNT_BITS-1:0] cnt_nxt;

  // Fetch PC bits outside the index field carry no information for an untagged table.
  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{i_fetch_pc[XLEN-1:IDX+2], i_fetch_pc[1:0]};

  assign fetch_idx    = i_fetch_pc[IDX+1:2];
  assign ex_idx       = i_ex_pc[IDX+1:2];
  assign o_pred_taken = bht[fetch_idx][CNT_BITS-1];

  assign pc4     = i_ex_pc + XLEN'(4);
  assign off_ext = {{(XLEN-18){i_ex_offset[15]}}, i_ex_offset, 2'b00};
  assign btgt    = pc4 + off_ext;
  assign jtgt    = {pc4[XLEN-1:28], i_ex_target, 2'b00};
  assign a_zero  = (i_ex_a == '0);
  assign a_neg   = i_ex_a[XLEN-1];

  always_comb begin
    is_cond = 1'b0;
    taken   = 1'b0;
    case (i_ex_brop)
      OP_BEQ:  begin is_cond = 1'b1; taken = (i_ex_a == i_ex_b);  end
      OP_BNE:  begin is_cond = 1'b1; taken = (i_ex_a != i_ex_b);  end
      OP_BLEZ: begin is_cond = 1'b1; taken = a_neg | a_zero;      end
      OP_BGTZ: begin is_cond = 1'b1; taken = ~a_neg & ~a_zero;    end
      default: begin is_cond = 1'b0; taken = 1'b0;                end
    endcase
  end

  assign mispredict = is_cond && (taken != i_ex_pred_taken);

  // Saturating step of the counter owned by the EX instruction.
  always_comb begin
    cnt_cur = bht[ex_idx];
    cnt_nxt = cnt_cur;
    if (taken) begin
      if (cnt_cur != CNT_MAX) cnt_nxt = cnt_cur + CNT_BITS'(1);
    end else begin
      if (cnt_cur != CNT_MIN) cnt_nxt = cnt_cur - CNT_BITS'(1);
    end
  end

  // The write lands at the edge, so a same-cycle lookup sees the old value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CNT_INIT;
    end else if (i_ex_valid && is_cond) begin
      bht[ex_idx] <= cnt_nxt;
    end
  end

  // Redirect and link-enable are pulses; PC and link data hold when nothing resolves.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_redirect       <= 1'b0;
      o_redirect_pc    <= '0;
      o_link_we        <= 1'b0;
      o_link_data      <= '0;
      o_mispredict_cnt <= '0;
    end else begin
      o_redirect <= 1'b0;
      o_link_we  <= 1'b0;
      if (i_ex_valid) begin
        case (i_ex_brop)
          OP_J: begin
            o_redirect    <= 1'b1;
            o_redirect_pc <= jtgt;
          end
          OP_JAL: begin
            o_redirect    <= 1'b1;
            o_redirect_pc <= jtgt;
            o_link_we     <= 1'b1;
            o_link_data   <= pc4;
          end
          OP_JR: begin
            o_redirect    <= 1'b1;
            o_redirect_pc <= {i_ex_a[XLEN-1:2], 2'b00};
          end
          OP_NONE: ;
          default: begin
            if (mispredict) begin
              o_redirect    <= 1'b1;
              o_redirect_pc <= taken ? btgt : pc4;
              if (o_mispredict_cnt != '1) o_mispredict_cnt <= o_mispredict_cnt + STAT_BITS'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised next-generation branch unit.
- Resolves conditional branches and jumps in EX, and predicts conditional-branch direction at fetch from a table of saturating counters.
- Issues a registered redirect only on a mispredict or an unconditional jump.
- Also provides JAL link data and a saturating mispredict statistic.

Parameters:
- XLEN, 32: datapath width. Must be >= 32.
- BHT_ENTRIES, 64: number of prediction counters. Power of two, >= 2. IDX = log2(BHT_ENTRIES).
- CNT_BITS, 2: counter width, >= 1. MSB = 1 means predict taken.
- STAT_BITS, 16: mispredict counter width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_fetch_pc  in  XLEN  fetch PC used for lookup
- o_pred_taken  out  1  combinational prediction for i_fetch_pc
- i_ex_valid  in  1  EX slot holds a valid instruction
- i_ex_pc  in  XLEN  PC of the EX instruction
- i_ex_brop  in  3  000 none, 001 BNE, 010 J, 011 JR, 100 BEQ, 101 BLEZ, 110 BGTZ, 111 JAL
- i_ex_a  in  XLEN  operand A (rs)
- i_ex_b  in  XLEN  operand B (rt)
- i_ex_offset  in  16  branch offset, in words
- i_ex_target  in  26  jump index
- i_ex_pred_taken  in  1  prediction carried down from fetch
- o_redirect  out  1  flush the front end and load o_redirect_pc
- o_redirect_pc  out  XLEN  corrected PC
- o_link_we  out  1  write o_link_data to r31
- o_link_data  out  XLEN  return address
- o_mispredict_cnt  out  STAT_BITS  saturating count of redirects caused by conditional branches

Behaviour:
- Reset (asynchronous, any time, including mid-resolve):
  - o_redirect = 0, o_redirect_pc = 0, o_link_we = 0, o_link_data = 0, o_mispredict_cnt = 0.
  - Every counter = 2^(CNT_BITS-1) - 1 (weakly not-taken; 01 for CNT_BITS = 2). Counter reset may use a per-entry reset; no init sequencer.
  - A resolution in flight at reset is discarded.
- Lookup:
  - Index = i_fetch_pc[IDX+1:2].
  - o_pred_taken = counter[index] MSB, purely combinational, zero cycles.
- Resolution: combinational in EX; results registered, so outputs are valid exactly 1 cycle after i_ex_valid is sampled.
- Intermediate values:
  - pc4 = i_ex_pc + 4, wrapping modulo 2^XLEN.
  - btgt = pc4 + (sign-extended i_ex_offset << 2), wrapping.
  - jtgt = {pc4[XLEN-1:28], i_ex_target, 2'b00}.
- Taken conditions:
  - BEQ: a == b.
  - BNE: a != b.
  - BLEZ: signed a <= 0.
  - BGTZ: signed a > 0. i_ex_b is ignored for BLEZ and BGTZ.
- Conditional branch, taken != i_ex_pred_taken: next o_redirect = 1, o_redirect_pc = taken ? btgt : pc4. o_mispredict_cnt increments and saturates at all-ones; it does not wrap.
- Conditional branch, prediction correct: next o_redirect = 0.
- J: o_redirect = 1, o_redirect_pc = jtgt.
- JAL: same as J, plus o_link_we = 1 and o_link_data = pc4.
- JR: o_redirect = 1, o_redirect_pc = i_ex_a with bits [1:0] forced to 0.
- Jumps always redirect and never touch the counters or o_mispredict_cnt.
- brop 000, or i_ex_valid = 0: next o_redirect = 0 and o_link_we = 0. o_redirect_pc and o_link_data hold their previous values. No counter update.
- Counter update:
  - Applies to valid conditional branches only, at the entry indexed by i_ex_pc[IDX+1:2].
  - Taken: +1, saturating at 2^CNT_BITS - 1. Not taken: -1, saturating at 0.
  - Write occurs at the clock edge. A lookup of the same index in the same cycle returns the pre-update value.
- Aliasing: PCs with equal index bits share a counter. No tags.
- o_redirect is a 1-cycle pulse per resolving instruction. Back-to-back valid instructions produce independent pulses. The unit has no stall input; upstream holds i_ex_valid low while EX is stalled.

Test Plan:
- Reset values: release reset; fetch pc 0x0000_0040 -> o_pred_taken = 0, all outputs 0.
- BEQ learning: BEQ at pc 0x100, a = b = 5, offset 0x0004, pred 0, three times.
  - Cycle after 1st: o_redirect = 1, o_redirect_pc = 0x114, o_mispredict_cnt = 1.
  - After the 1st update the counter is 10, so lookup 0x100 gives 1. Counter saturates at 11 after the 2nd.
  - 2nd and 3rd issues with pred 1: o_redirect = 0.
- BNE fallthrough: pc 0x200, a = 1, b = 1, pred 1 -> o_redirect_pc = 0x204, count increments. Negative offset: BEQ at 0x200, offset 0xFFFE, taken, pred 0 -> 0x1FC.
- Jumps:
  - JAL at pc 0x1000_0008, target 0x000_0040 -> o_redirect = 1, o_redirect_pc = 0x1000_0100, o_link_we = 1, o_link_data = 0x1000_000C.
  - JR with a = 0x0000_3003 -> o_redirect_pc = 0x0000_3000.
  - Neither changes o_mispredict_cnt.
- Same-cycle hazard and saturation:
  - Resolve a BGTZ taken at 0x300 while fetching 0x300 -> pre-update prediction seen that cycle, updated value the next cycle.
  - Force STAT_BITS = 2 and 5 mispredicts -> count holds at 3.
- Async reset mid-flight: assert i_rst_n low between clock edges while o_redirect = 1 -> o_redirect drops immediately and all counters return to 01.
